// File: rtl/i2c_reg_pkg.sv
// i2c_reg_pkg: shared widths and FSM states for the I2C/host register arbiter
package i2c_reg_pkg;
  localparam int REG_ADDR_W = 8;
  localparam int REG_DATA_W = 8;
  typedef enum logic [2:0] {
    IDLE,
    I2C_RD,
    I2C_RD_WAIT,
    I2C_RD_HOLD,
    I2C_WR,
    HOST_RD,
    HOST_RD_WAIT,
    HOST_WR
  } state_t;
endpackage

// File: rtl/i2c_reg_arbiter.sv
// i2c_reg_arbiter: round-robin sharing of a 256x8 register RAM between an I2C peripheral and a host
module i2c_reg_arbiter
  import i2c_reg_pkg::*;
#(
  parameter int HOLD_TIMEOUT = 15000
) (
  input  logic                  i_sys_clk,
  input  logic                  i_rst,
  input  logic [REG_ADDR_W-1:0] i_i2c_addr,
  input  logic                  i_i2c_read_enable,
  output logic [REG_DATA_W-1:0] o_i2c_read_data,
  output logic                  o_i2c_read_valid,
  input  logic                  i_i2c_read_ack,
  input  logic [REG_DATA_W-1:0] i_i2c_wdata,
  input  logic                  i_i2c_write_valid,
  output logic                  o_i2c_write_ack,
  input  logic                  i_host_req,
  input  logic                  i_host_we,
  input  logic [REG_ADDR_W-1:0] i_host_addr,
  input  logic [REG_DATA_W-1:0] i_host_wdata,
  output logic                  o_host_gnt,
  output logic [REG_DATA_W-1:0] o_host_rdata,
  output logic                  o_host_rvalid,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [REG_ADDR_W-1:0] o_mem_addr,
  output logic [REG_DATA_W-1:0] o_mem_wdata,
  input  logic [REG_DATA_W-1:0] i_mem_rdata,
  output logic                  o_timeout_err
);
  localparam int CW = $clog2(HOLD_TIMEOUT + 1);
  state_t state, state_nx;
  logic last_i2c, wr_block;
  logic [CW-1:0] hold_cnt;
  logic i2c_req, pick_i2c, pick_host, hold_to, hold_exit, i2c_st, host_st;
  always_comb begin
    i2c_req   = i_i2c_read_enable | (i_i2c_write_valid & ~wr_block);
    pick_i2c  = i2c_req & (~i_host_req | ~last_i2c);
    pick_host = i_host_req & ~pick_i2c;
    hold_to   = hold_cnt == CW'(HOLD_TIMEOUT - 1);
    hold_exit = i_i2c_read_ack | ~i_i2c_read_enable | hold_to;
    i2c_st    = state == I2C_RD || state == I2C_WR;
    host_st   = state == HOST_RD || state == HOST_WR;
    o_mem_en        = i2c_st | host_st;
    o_mem_we        = state == I2C_WR || state == HOST_WR;
    o_i2c_write_ack = state == I2C_WR;
    o_host_gnt      = host_st;
    o_mem_addr      = i2c_st ? i_i2c_addr : host_st ? i_host_addr : '0;
    o_mem_wdata     = state == I2C_WR ? i_i2c_wdata : state == HOST_WR ? i_host_wdata : '0;
    state_nx = IDLE;
    case (state)
      IDLE:         state_nx = pick_i2c ? (i_i2c_read_enable ? I2C_RD : I2C_WR)
                             : pick_host ? (i_host_we ? HOST_WR : HOST_RD) : IDLE;
      I2C_RD:       state_nx = I2C_RD_WAIT;
      I2C_RD_WAIT:  state_nx = I2C_RD_HOLD;
      I2C_RD_HOLD:  state_nx = hold_exit ? IDLE : I2C_RD_HOLD;
      HOST_RD:      state_nx = HOST_RD_WAIT;
      default:      state_nx = IDLE;
    endcase
  end
  // write_valid is masked for one IDLE cycle after a write so a slow deassert is not seen as a new request
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      state            <= IDLE;
      last_i2c         <= 1'b0;
      wr_block         <= 1'b0;
      hold_cnt         <= '0;
      o_i2c_read_data  <= '0;
      o_i2c_read_valid <= 1'b0;
      o_host_rdata     <= '0;
      o_host_rvalid    <= 1'b0;
      o_timeout_err    <= 1'b0;
    end else begin
      state         <= state_nx;
      wr_block      <= state == I2C_WR;
      o_host_rvalid <= state == HOST_RD_WAIT;
      hold_cnt      <= state != I2C_RD_HOLD ? '0
                     : hold_cnt == CW'(HOLD_TIMEOUT) ? hold_cnt : hold_cnt + CW'(1);
      if (state == IDLE && (pick_i2c || pick_host)) last_i2c <= pick_i2c;
      if (state == HOST_RD_WAIT) o_host_rdata <= i_mem_rdata;
      if (state == I2C_RD_WAIT) begin
        o_i2c_read_data  <= i_mem_rdata;
        o_i2c_read_valid <= 1'b1;
      end else if (state == I2C_RD_HOLD && hold_exit) begin
        o_i2c_read_valid <= 1'b0;
      end
      if (state == I2C_RD_HOLD && hold_to && i_i2c_read_enable && !i_i2c_read_ack) o_timeout_err <= 1'b1;
    end
  end
endmodule

// File: doc/i2c_reg_arbiter.md
I2C_REG_ARBITER -- requirements
Module: i2c_reg_arbiter

Interface
REQ-001 SHALL have parameter HOLD_TIMEOUT, default 15000, max cycles o_i2c_read_valid is held awaiting i_i2c_read_ack.
REQ-002 SHALL have one clock and an asynchronous, active-high reset:
- i_sys_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  asynchronous active-high reset
REQ-003 SHALL have the I2C-peripheral port:
- i_i2c_addr  in  8  register address
- i_i2c_read_enable  in  1  read request, level
- o_i2c_read_data  out  8  read data
- o_i2c_read_valid  out  1  read data valid, level
- i_i2c_read_ack  in  1  read data consumed
- i_i2c_wdata  in  8  write data
- i_i2c_write_valid  in  1  write request, level
- o_i2c_write_ack  out  1  write accepted, pulse
REQ-004 SHALL have the host port:
- i_host_req  in  1  request, held until grant
- i_host_we  in  1  1=write, 0=read
- i_host_addr  in  8  address
- i_host_wdata  in  8  write data
- o_host_gnt  out  1  accepted, pulse
- o_host_rdata  out  8  read data
- o_host_rvalid  out  1  read data valid, pulse
REQ-005 SHALL have the memory port, single-port 256x8 RAM, 1-cycle read latency:
- o_mem_en  out  1  access strobe
- o_mem_we  out  1  write strobe
- o_mem_addr  out  8  address
- o_mem_wdata  out  8  write data
- i_mem_rdata  in  8  valid the cycle after o_mem_en with o_mem_we=0
REQ-006 SHALL have o_timeout_err  out  1, a sticky flag set on a read-hold timeout.

Function
REQ-007 FSM states: IDLE, I2C_RD, I2C_RD_WAIT, I2C_RD_HOLD, I2C_WR, HOST_RD, HOST_RD_WAIT, HOST_WR.
REQ-008 I2C request = i_i2c_read_enable | i_i2c_write_valid. If both are asserted, read wins.
REQ-009 IDLE arbitration is round-robin between I2C and host using a last_grant bit. With both pending, grant the side not served last. A lone requester is granted immediately. last_grant updates on each grant.
REQ-010 I2C_RD: o_mem_en=1, o_mem_we=0, o_mem_addr=i_i2c_addr for one cycle, then go to I2C_RD_WAIT.
REQ-011 I2C_RD_WAIT: capture i_mem_rdata into o_i2c_read_data and set o_i2c_read_valid, both registered, then go to I2C_RD_HOLD. Valid first asserts 3 cycles after IDLE samples i_i2c_read_enable.
REQ-012 I2C_RD_HOLD: hold valid and data until i_i2c_read_ack=1, then clear valid next edge and go to IDLE.
REQ-013 I2C_RD_HOLD abort cases, each clearing valid and returning to IDLE:
- i_i2c_read_enable=0 without ack: peripheral aborted; no error.
- Hold count reaches HOLD_TIMEOUT: set o_timeout_err.
REQ-014 I2C_WR: o_mem_en=1, o_mem_we=1, address and data taken from the I2C port, o_i2c_write_ack=1, all for exactly one cycle, then go to IDLE. IDLE does not re-sample write_valid in the cycle it drops.
REQ-015 HOST_RD: o_mem_en=1, o_host_gnt=1 for one cycle. HOST_RD_WAIT: o_host_rdata<=i_mem_rdata and o_host_rvalid pulses the following cycle, concurrent with IDLE.
REQ-016 HOST_WR: o_mem_en=1, o_mem_we=1, o_host_gnt=1 for one cycle, then go to IDLE.
REQ-017 o_mem_en, o_mem_we, o_i2c_write_ack and o_host_gnt SHALL be decoded from the current state only. o_mem_addr and o_mem_wdata SHALL be 0 when o_mem_en=0.
REQ-018 At most one memory access per cycle. A grant is never issued outside IDLE. A requester waits at most one foreign transaction.
REQ-019 The hold counter is clog2(HOLD_TIMEOUT+1) bits, cleared on entry to I2C_RD_HOLD, saturating.

Reset
REQ-020 i_rst=1 SHALL asynchronously force state to IDLE, last_grant to host (so I2C wins first tie), all outputs to 0, and clear the counter and o_timeout_err.
REQ-021 Reset mid-transaction SHALL drop any pending ack, grant or valid with no memory write. Operation resumes in IDLE on the first edge after deassertion.

Structure
REQ-022 Package i2c_reg_pkg SHALL hold the state enum, REG_ADDR_W=8 and REG_DATA_W=8.
REQ-023 The block SHALL be flat, with no sub-module; the 2-way arbiter is inline logic.

Verification
REQ-024 I2C read: memory preloaded with 0x5A at address 0x10. Read enable with addr=0x10 -> o_mem_en at +1, valid with data=0x5A at +3. Ack -> valid low next cycle.
REQ-025 I2C write: addr=0x22, wdata=0xC3, write_valid -> one-cycle ack together with mem we, addr 0x22, data 0xC3. Exactly one write occurs.
REQ-026 Simultaneous I2C read and host write after reset -> I2C served first. A second simultaneous pair -> host served first.
REQ-027 Read abort: read enable drops in I2C_RD_HOLD with no ack -> valid low next cycle, state IDLE, o_timeout_err=0.
REQ-028 Timeout: HOLD_TIMEOUT=16, ack never given -> valid drops after 16 hold cycles, o_timeout_err=1 until reset.
REQ-029 Reset during HOST_WR -> no write, gnt=0 immediately. A host read of 0x10 after release -> rvalid with 0x5A.
